uart_tx: RTL and testbench

Serial transmitter, the counterpart of the CPU's UART RX programming path: accepts one byte over a valid/ready handshake and shifts it out as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed baud rate. It sits beside the CPU core and lets memory contents and OUT-instruction results be streamed back to the host programmer over a single pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 36 +++
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_DATA_LENGTH           = 8;
   localparam int TX_COUNTER_BITWIDTH        = 3;
   localparam int BAUD_COUNTS_PER_BIT        = 521;   // 10 MHz clock
   localparam int BAUD_RATE_COUNTER_BITWIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..COUNTS-1 while enabled, flags the last cycle of each period.
// Latency: tc_o is combinational from the count register; the count wraps to 0 on tc_o.
// Backpressure: none; clr_i has priority over en_i and restarts the period.
module uart_baud_counter #(
   parameter int COUNTS = 521,
   parameter int WIDTH  = 10
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Terminal count: last cycle of the current bit period.
   assign tc_o = en_i && (cnt_q == WIDTH'(COUNTS - 1));

   // Next count: clear, wrap on terminal count, otherwise advance when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one byte per valid/ready handshake, LSB first, fixed baud.
// Latency: start bit appears one cycle after the handshake edge; frame is 10 bit periods.
// Backpressure: ready_o only in IDLE; valid_i outside IDLE is ignored and the byte is dropped.
module uart_tx #(
   parameter int UART_DATA_LENGTH           = uart_pkg::UART_DATA_LENGTH,
   parameter int TX_COUNTER_BITWIDTH        = uart_pkg::TX_COUNTER_BITWIDTH,
   parameter int BAUD_COUNTS_PER_BIT        = uart_pkg::BAUD_COUNTS_PER_BIT,
   parameter int BAUD_RATE_COUNTER_BITWIDTH = uart_pkg::BAUD_RATE_COUNTER_BITWIDTH
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic [UART_DATA_LENGTH-1:0] data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic                        done_strb_o
);

   import uart_pkg::*;

   // The baud counter must be able to reach BAUD_COUNTS_PER_BIT-1.
   if ((2 ** BAUD_RATE_COUNTER_BITWIDTH) < BAUD_COUNTS_PER_BIT) begin : g_baud_width_check
      $error("uart_tx: BAUD_RATE_COUNTER_BITWIDTH too small for BAUD_COUNTS_PER_BIT");
   end

   // The bit counter wraps naturally from the last data bit back to 0.
   if ((2 ** TX_COUNTER_BITWIDTH) != UART_DATA_LENGTH) begin : g_bit_width_check
      $error("uart_tx: 2**TX_COUNTER_BITWIDTH must equal UART_DATA_LENGTH");
   end

   uart_state_e                   state_q, state_d;
   logic [UART_DATA_LENGTH-1:0]   shift_q, shift_d;
   logic [TX_COUNTER_BITWIDTH-1:0] bit_q, bit_d;
   logic                          tx_q, tx_d;
   logic                          done_q, done_d;
   logic                          baud_en, baud_clr, baud_tc;

   assign baud_en = (state_q != ST_IDLE);

   uart_baud_counter #(
      .COUNTS (BAUD_COUNTS_PER_BIT),
      .WIDTH  (BAUD_RATE_COUNTER_BITWIDTH)
   ) u_baud (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (baud_en),
      .clr_i    (baud_clr),
      .tc_o     (baud_tc)
   );

   // Next state, shift/bit counters, and the registered line level for the next cycle.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      done_d   = 1'b0;
      baud_clr = 1'b0;
      tx_d     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               state_d  = ST_START;
               shift_d  = data_i;
               bit_d    = '0;
               baud_clr = 1'b1;
            end
         end
         ST_START: begin
            if (baud_tc) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_tc) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1)) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (baud_tc) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Line level is derived from where the FSM will be, so tx_o is a plain flop.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers; reset forces the line idle-high at once.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign ready_o     = (state_q == ST_IDLE);
   assign busy_o      = ~ready_o;
   assign tx_o        = tx_q;
   assign done_strb_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fast-baud instance (B=4) for protocol cases, default instance for timing.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stimulus waits (bounded) for ready_o before each handshake.
module tb_uart_tx;

   localparam int BF = 4;     // fast instance bit period
   localparam int BD = 521;   // default instance bit period

   logic       clk = 1'b0;
   logic       reset_ni;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, tx_a, busy_a, done_a;
   logic       ready_b, tx_b, busy_b, done_b;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   uart_tx #(.BAUD_COUNTS_PER_BIT(BF)) u_fast (
      .clk_i(clk), .reset_ni(reset_ni), .data_i(data_a), .valid_i(valid_a),
      .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_strb_o(done_a)
   );

   uart_tx u_dflt (
      .clk_i(clk), .reset_ni(reset_ni), .data_i(data_b), .valid_i(valid_b),
      .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_strb_o(done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for ready, present a byte, and record it as expected on the line.
   task automatic handshake(input bit sel, input logic [7:0] b, input bit hold);
      int n;
      n = 0;
      while (!(sel ? ready_b : ready_a) && n < 100) begin
         tick();
         n++;
      end
      check("hs_ready", {31'd0, sel ? ready_b : ready_a}, 32'd1);
      if (sel) begin data_b = b; valid_b = 1'b1; end
      else     begin data_a = b; valid_a = 1'b1; end
      tick();
      sb_q.push_back(b);
      if (!hold) begin
         if (sel) valid_b = 1'b0;
         else     valid_a = 1'b0;
      end
   endtask

   // Called at the first sample after the handshake; ends at the cycle after the frame.
   task automatic receive_frame(input bit sel, input int bw, input string tag,
                                input int intr_at, output logic [9:0] bits);
      int         unstable, rdy_bad, done_cnt, k;
      logic       cur;
      logic [7:0] exp_b;
      unstable = 0; rdy_bad = 0; done_cnt = 0;
      bits = '0;
      for (int s = 1; s <= 10 * bw; s++) begin
         if (s > 1) tick();
         if (intr_at > 0 && s == intr_at)     begin valid_a = 1'b1; data_a = 8'h3C; end
         if (intr_at > 0 && s == intr_at + 3) begin valid_a = 1'b0; data_a = 8'hE7; end
         cur = sel ? tx_b : tx_a;
         k = (s - 1) / bw;
         if ((s - 1) % bw == 0) bits[k] = cur;
         else if (cur !== bits[k]) unstable++;
         if ((sel ? ready_b : ready_a) !== 1'b0) rdy_bad++;
         if ((sel ? busy_b : busy_a) !== 1'b1) rdy_bad++;
         if ((sel ? done_b : done_a) !== 1'b0) done_cnt++;
      end
      check({tag, "_start"},    {31'd0, bits[0]}, 32'd0);
      check({tag, "_stop"},     {31'd0, bits[9]}, 32'd1);
      check({tag, "_bitwidth"}, unstable, 32'd0);
      check({tag, "_busy"},     rdy_bad, 32'd0);
      check({tag, "_early_done"}, done_cnt, 32'd0);
      tick();
      check({tag, "_done"},  {31'd0, sel ? done_b  : done_a},  32'd1);
      check({tag, "_ready"}, {31'd0, sel ? ready_b : ready_a}, 32'd1);
      check({tag, "_idle"},  {31'd0, sel ? tx_b    : tx_a},    32'd1);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp_b = sb_q.pop_front();
         check({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, exp_b});
      end
   endtask

   initial begin
      logic [9:0] bits;
      int         done_seen;
      reset_ni = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0;
      data_a = 8'h00; data_b = 8'h00;

      // Reset values.
      repeat (3) tick();
      check("rst_tx",    {31'd0, tx_a},    32'd1);
      check("rst_ready", {31'd0, ready_a}, 32'd1);
      check("rst_busy",  {31'd0, busy_a},  32'd0);
      check("rst_done",  {31'd0, done_a},  32'd0);
      reset_ni = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 2 * BF; i++) begin
         tick();
         if (tx_a !== 1'b1 || done_a !== 1'b0 || ready_a !== 1'b1) done_seen++;
      end
      check("post_rst_quiet", done_seen, 32'd0);

      // Single frame 0xA5: exact line sequence and a single done pulse.
      handshake(1'b0, 8'hA5, 1'b0);
      receive_frame(1'b0, BF, "a5", 0, bits);
      check("a5_wave", {22'd0, bits}, {22'd0, 10'b11_0100_1010});
      tick();
      check("a5_done_once", {31'd0, done_a}, 32'd0);

      // Back-to-back 0x00 then 0xFF with valid held: next start bit directly follows the done cycle.
      handshake(1'b0, 8'h00, 1'b1);
      data_a = 8'hFF;
      sb_q.push_back(8'hFF);
      receive_frame(1'b0, BF, "b2b0", 0, bits);
      check("b2b0_wave", {22'd0, bits}, {22'd0, 10'b10_0000_0000});
      tick();
      valid_a = 1'b0;
      receive_frame(1'b0, BF, "b2b1", 0, bits);
      check("b2b1_wave", {22'd0, bits}, {22'd0, 10'b11_1111_1110});

      // Intruding 0x3C during the DATA state of 0x81 is dropped.
      handshake(1'b0, 8'h81, 1'b0);
      receive_frame(1'b0, BF, "intr", 14, bits);
      check("intr_sb_drained", sb_q.size(), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 3 * BF; i++) begin
         tick();
         if (tx_a !== 1'b1 || ready_a !== 1'b1) done_seen++;
      end
      check("intr_no_resend", done_seen, 32'd0);

      // Reset mid-DATA: line goes high without waiting for a clock edge, no done pulse.
      handshake(1'b0, 8'h00, 1'b0);
      repeat (9) tick();
      check("mid_rst_pre_tx", {31'd0, tx_a}, 32'd0);
      reset_ni = 1'b0;
      #1;
      check("mid_rst_tx_async", {31'd0, tx_a},    32'd1);
      check("mid_rst_ready",    {31'd0, ready_a}, 32'd1);
      sb_q.delete();
      tick();
      reset_ni = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 10 * BF; i++) begin
         tick();
         if (done_a !== 1'b0 || tx_a !== 1'b1) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 32'd0);
      handshake(1'b0, 8'h5A, 1'b0);
      receive_frame(1'b0, BF, "after_rst", 0, bits);

      // Default baud: 0x55 frame, every bit 521 cycles wide, 5210 cycles total.
      handshake(1'b1, 8'h55, 1'b0);
      receive_frame(1'b1, BD, "dflt", 0, bits);
      check("dflt_wave", {22'd0, bits}, {22'd0, 10'b10_1010_1010});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
